// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// BRANCH_NE_EN (when defined) adds bne on top of beq.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Coarse ALU request from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:     imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, controls out.
// master = controller, slave = datapath.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [2:0] alucontrol;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alucontrol, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alucontrol, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields to a 3-bit alucontrol.
// funct3 011 has no ALU meaning and is flagged for the decode stage.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alucontrol,
  output logic       o_funct_illegal
);

  always_comb begin
    o_funct_illegal = (i_funct3 == 3'b011);
    o_alucontrol    = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      default: begin
        case (i_funct3)
          // op[5] separates R-type from I-type; addi never subtracts
          3'b000:  o_alucontrol = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alucontrol = ALU_SLL;
          3'b010:  o_alucontrol = ALU_SLT;
          3'b100:  o_alucontrol = ALU_XOR;
          3'b101:  o_alucontrol = ALU_SRL;
          3'b110:  o_alucontrol = ALU_OR;
          3'b111:  o_alucontrol = ALU_AND;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch..writeback, drives datapath controls.
// Optional: define BRANCH_NE_EN to accept bne (branch on !zero) via the BEQ state.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int RESET_STATE_HOLD = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multicycle_controller_if.master   bus
);

  state_t     r_state;
  state_t     w_dec_next;
  logic       w_dec_illegal;
  logic       w_branch_legal;
  logic       w_funct_illegal;
  logic       w_taken;
  logic       w_we_ok;
  logic       w_pc_update, w_branch, w_adr_src, w_mem_write, w_ir_write;
  logic       w_reg_write, w_done, w_illegal;
  logic [1:0] w_result_src, w_src_a, w_src_b, w_alu_op;
  logic [2:0] w_alucontrol;

  alu_decoder u_alu_dec (
    .i_alu_op        (w_alu_op),
    .i_funct3        (bus.funct3),
    .i_funct7b5      (bus.funct7b5),
    .i_op5           (bus.op[5]),
    .o_alucontrol    (w_alucontrol),
    .o_funct_illegal (w_funct_illegal)
  );

`ifdef BRANCH_NE_EN
  assign w_branch_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
  assign w_taken        = bus.funct3[0] ? ~bus.zero : bus.zero;
`else
  assign w_branch_legal = (bus.funct3 == 3'b000);
  assign w_taken        = bus.zero;
`endif

  always_comb begin
    w_dec_next    = FETCH;
    w_dec_illegal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW: w_dec_next = MEMADR;
      OP_R: begin
        w_dec_next    = w_funct_illegal ? FETCH : EXECUTER;
        w_dec_illegal = w_funct_illegal;
      end
      OP_I: begin
        w_dec_next    = w_funct_illegal ? FETCH : EXECUTEI;
        w_dec_illegal = w_funct_illegal;
      end
      OP_BRANCH: begin
        w_dec_next    = w_branch_legal ? BEQ : FETCH;
        w_dec_illegal = ~w_branch_legal;
      end
      OP_JAL:  w_dec_next    = JAL;
      default: w_dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:              r_state <= DECODE;
        DECODE:             r_state <= w_dec_next;
        MEMADR:             r_state <= (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:            r_state <= MEMWB;
        EXECUTER, EXECUTEI: r_state <= ALUWB;
        JAL:                r_state <= ALUWB;
        default:            r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = RES_ALUOUT;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      FETCH: begin
        w_ir_write   = 1'b1;
        w_src_b      = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_pc_update  = 1'b1;
      end
      DECODE: begin
        w_src_a   = SRCA_OLDPC;
        w_src_b   = SRCB_IMM;
        w_illegal = w_dec_illegal;
        w_done    = w_dec_illegal;
      end
      MEMADR: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
      end
      MEMREAD:  w_adr_src = 1'b1;
      MEMWB: begin
        w_result_src = RES_RDATA;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_done      = 1'b1;
      end
      EXECUTER: begin
        w_src_a  = SRCA_RS1;
        w_alu_op = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        w_src_a  = SRCA_RS1;
        w_src_b  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      BEQ: begin
        w_src_a  = SRCA_RS1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
        w_done   = 1'b1;
      end
      JAL: begin
        w_src_a     = SRCA_OLDPC;
        w_src_b     = SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are held off combinationally for the whole reset window
  assign w_we_ok = (RESET_STATE_HOLD == 0) || reset_n;

  // w_branch is 0 outside BEQ, so an unknown zero there cannot reach pc_write
  assign bus.pc_write   = w_we_ok & (w_pc_update | (w_branch & w_taken));
  assign bus.mem_write  = w_we_ok & w_mem_write;
  assign bus.ir_write   = w_we_ok & w_ir_write;
  assign bus.reg_write  = w_we_ok & w_reg_write;
  assign bus.instr_done = w_we_ok & w_done;
  assign bus.illegal    = w_we_ok & w_illegal;
  assign bus.adr_src    = w_adr_src;
  assign bus.result_src = w_result_src;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.alucontrol = w_alucontrol;
  assign bus.imm_src    = imm_sel(bus.op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors
// come from an instruction-level model; a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;
  localparam int K_F = 0, K_D = 1, K_MA = 2, K_MR = 3, K_MWB = 4, K_MW = 5,
                 K_EX = 6, K_WB = 7, K_BR = 8, K_J = 9;

  typedef struct {
    logic [17:0] v;
    int          idx;
    int          ph;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;
  int   inum = 0;

  multicycle_controller_if bus();

  multicycle_controller #(.RESET_STATE_HOLD(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  wire [17:0] act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                     bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                     bus.reg_write, bus.alucontrol, bus.instr_done, bus.illegal};

  function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
      input logic [1:0] imm, input logic rw, input logic [2:0] alu, input logic done,
      input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, done, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int cls_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return (f3 == 3'd3) ? C_ILL : C_R;
      7'b0010011: return (f3 == 3'd3) ? C_ILL : C_I;
`ifdef BRANCH_NE_EN
      7'b1100011: return (f3 == 3'd0 || f3 == 3'd1) ? C_BR : C_ILL;
`else
      7'b1100011: return (f3 == 3'd0) ? C_BR : C_ILL;
`endif
      7'b1101111: return C_JAL;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int len_of(input int c);
    int lens [7] = '{5, 4, 4, 4, 3, 4, 2};
    return lens[c];
  endfunction

  function automatic int kind_of(input int c, input int ph);
    if (ph == 0) return K_F;
    if (ph == 1) return K_D;
    case (c)
      C_LW:    return (ph == 2) ? K_MA : (ph == 3) ? K_MR : K_MWB;
      C_SW:    return (ph == 2) ? K_MA : K_MW;
      C_R, C_I: return (ph == 2) ? K_EX : K_WB;
      C_BR:    return K_BR;
      default: return (ph == 2) ? K_J : K_WB;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input int c, input logic [2:0] f3, input logic f7);
    logic [2:0] tab [8] = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    if (f3 == 3'd0) return (c == C_R && f7) ? 3'd1 : 3'd0;
    return tab[f3];
  endfunction

  function automatic logic [17:0] model(input int c, input int ph, input logic [6:0] op,
      input logic [2:0] f3, input logic f7, input logic z);
    logic [1:0] im;
    logic       tk;
    im = imm_of(op);
    case (kind_of(c, ph))
      K_F:   return pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, im, 0, 3'd0, 0, 0);
      K_D:   return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 0, 3'd0,
                       c == C_ILL, c == C_ILL);
      K_MA:  return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 0, 3'd0, 0, 0);
      K_MR:  return pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 0, 3'd0, 0, 0);
      K_MWB: return pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, im, 1, 3'd0, 1, 0);
      K_MW:  return pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, im, 0, 3'd0, 1, 0);
      K_EX:  return pk(0, 0, 0, 0, 2'b00, 2'b10, (c == C_R) ? 2'b00 : 2'b01, im, 0,
                       alu_of(c, f3, f7), 0, 0);
      K_WB:  return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 1, 3'd0, 1, 0);
      K_BR: begin
        tk = (f3 == 3'd1) ? ~z : z;
        return pk(tk, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 0, 3'd1, 1, 0);
      end
      default: return pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 0, 3'd0, 0, 0);
    endcase
  endfunction

  function automatic logic [17:0] reset_vec(input logic [6:0] op);
    return pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm_of(op), 0, 3'd0, 0, 0);
  endfunction

  task automatic push(input logic [17:0] v, input int ph);
    exp_t e;
    e.v = v; e.idx = inum; e.ph = ph;
    q.push_back(e);
  endtask

  // zbr: forced zero in the branch cycle (-1 = random); abort_at: phase where reset hits
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zbr, input int abort_at);
    int c, n, r;
    c = cls_of(op, f3);
    n = len_of(c);
    for (int ph = 0; ph < n; ph++) begin
      @(posedge clk); #1;
      bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
      if (kind_of(c, ph) == K_BR)
        bus.zero = (zbr >= 0) ? zbr[0] : 1'($urandom_range(0, 1));
      else begin
        r = $urandom_range(0, 2);
        bus.zero = (r == 2) ? 1'bx : r[0];
      end
      if (ph == abort_at) begin
        reset_n = 1'b0;
        push(reset_vec(op), ph);
        @(posedge clk); #1;
        push(reset_vec(op), ph + 1);
        inum++;
        return;
      end
      reset_n = 1'b1;
      push(model(c, ph, op, f3, f7, bus.zero), ph);
    end
    inum++;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        nvec++;
        if (act !== e.v) begin
          nmis++;
          $display("FAIL instr%0d phase%0d: got %b want %b", e.idx, e.ph, act, e.v);
        end
      end
    end
  end

  initial begin : stim
    logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111};
    logic [6:0] op;
    logic [2:0] f3;
    int k;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    @(posedge clk); #1;
    push(reset_vec(bus.op), 0);
    run_instr(7'b0110011, 3'd0, 1'b0, -1, -1);   // add
    run_instr(7'b0110011, 3'd0, 1'b1, -1, -1);   // sub
    run_instr(7'b0010011, 3'd0, 1'b1, -1, -1);   // addi, f7b5 ignored
    run_instr(7'b0000011, 3'd2, 1'b0, -1, -1);   // lw
    run_instr(7'b0100011, 3'd2, 1'b0, -1, -1);   // sw
    run_instr(7'b1100011, 3'd0, 1'b0,  1, -1);   // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0,  0, -1);   // beq not taken
    run_instr(7'b0000000, 3'd0, 1'b0, -1, -1);   // illegal opcode
    run_instr(7'b0110011, 3'd3, 1'b0, -1, -1);   // illegal funct3
    run_instr(7'b1100011, 3'd1, 1'b0,  0, -1);   // bne
    run_instr(7'b1101111, 3'd0, 1'b0, -1, -1);   // jal
    run_instr(7'b0000011, 3'd2, 1'b0, -1, 2);    // reset in MEMADR
    run_instr(7'b0010011, 3'd4, 1'b0, -1, -1);   // xori after reset
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 6);
      f3 = 3'($urandom_range(0, 7));
      if (k == 6) begin
        op = 7'($urandom_range(0, 127));
        if (cls_of(op, 3'd0) != C_ILL) op = 7'd0;
      end else begin
        op = ops[k];
        if (k <= 1) f3 = 3'd2;
        if (k == 4 && $urandom_range(0, 1) == 1) f3 = 3'd0;
      end
      run_instr(op, f3, 1'($urandom_range(0, 1)), -1,
                ($urandom_range(0, 19) == 0) ? 1 + $urandom_range(0, 1) : -1);
    end
    @(negedge clk); #1;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I core.
- Upstream end of the ALU interface: drives the 3-bit ALU operation code into the datapath ALU and consumes its zero flag for branch resolution.
- Sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Drives all datapath mux selects and write enables.

Parameters:
- RESET_STATE_HOLD, 1, when 1 all write enables are forced 0 while reset_n is low.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  instruction[6:0] from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- zero  in  1  ALU result == 0.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address: 0 = PC, 1 = result bus.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register and OldPC enable.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 register.
- alu_src_b  out  2  00 rs2 register, 01 ImmExt, 10 constant 4.
- imm_src  out  2  00 I, 01 S, 10 B, 11 J.
- reg_write  out  1  register file write enable.
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  one-cycle pulse in DECODE when the opcode or funct3 is unsupported.

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous, active-low, and forces the state register to FETCH.
- Output style: all outputs are combinational from state/op/funct/zero (Moore style, except pc_write).
- Reset values of outputs: with RESET_STATE_HOLD=1, pc_write, ir_write, reg_write, mem_write, instr_done and illegal are 0 while reset_n is low. All other outputs take their FETCH values: adr_src 0, alu_src_a 00, alu_src_b 10, alucontrol 000, result_src 10.
- Reset mid-instruction: the instruction is abandoned and execution restarts at FETCH on the first clk edge after release.
- imm_src decode (from op in every state): sw → 01, beq → 10, jal → 11, else 00.
- pc_write = pc_update OR (branch AND zero).
- States and outputs (unlisted outputs are 0):
  - FETCH: adr_src 0, ir_write 1, a 00, b 10, ALU add, result_src 10, pc_update 1 → DECODE.
  - DECODE: a 01, b 01, ALU add (branch target into ALUOut). Next state by op:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 with funct3 000 → BEQ.
    - 1101111 → JAL.
    - Anything else → FETCH with illegal=1 and instr_done=1; the instruction acts as a NOP with the PC already advanced.
  - MEMADR: a 10, b 01, ALU add → MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: result_src 00, adr_src 1 → MEMWB.
  - MEMWB: result_src 01, reg_write 1, instr_done → FETCH.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1, instr_done → FETCH.
  - EXECUTER: a 10, b 00, ALU from funct decode → ALUWB.
  - EXECUTEI: a 10, b 01, ALU from funct decode → ALUWB.
  - ALUWB: result_src 00, reg_write 1, instr_done → FETCH.
  - BEQ: a 10, b 00, ALU sub, result_src 00, branch 1, instr_done → FETCH.
  - JAL: a 01, b 10, ALU add, result_src 00, pc_update 1 → ALUWB.
- Funct decode to alucontrol:
  - funct3 000: sub when op=0110011 and funct7b5=1, else add.
  - 001 → 110 (sll).
  - 010 → 101 (slt).
  - 100 → 100 (xor).
  - 101 → 111 (srl; funct7b5 ignored, sra unsupported).
  - 110 → 011 (or).
  - 111 → 010 (and).
  - 011 → illegal in DECODE, NOP as above.
- Latency in cycles: lw 5; sw, R-type, I-type and jal 4; beq 3; illegal 2.
- Boundary: zero is sampled only in the BEQ state. If zero is X outside BEQ, pc_write must remain known.

Optional Feature:
- Macro BRANCH_NE_EN.
- Defined: op 1100011 with funct3 001 (bne) is legal and uses the BEQ state with branch taken on NOT zero.
- Undefined: bne is illegal (illegal pulse, NOP).

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (FETCH..JAL);
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BRANCH, OP_JAL;
  - alucontrol localparams ALU_ADD..ALU_SRL;
  - mux select localparams for result_src, alu_src_a, alu_src_b, imm_src.
- One sub-module: alu_decoder, combinational. Inputs alu_op[1:0], funct3, funct7b5, op[5]; outputs alucontrol and funct_illegal.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0) → FETCH, DECODE, EXECUTER (alucontrol 000), ALUWB (reg_write 1, instr_done 1), then FETCH; 4 cycles.
- sub (f7b5 1) → alucontrol 001 in EXECUTER; addi with f7b5 1 → alucontrol 000.
- lw (op 0000011) → 5 cycles; adr_src 1 in MEMREAD; result_src 01 and reg_write 1 in MEMWB. sw → mem_write 1 only in cycle 4.
- beq with zero=1 → pc_write 1 in cycle 3. beq with zero=0 → pc_write 0 in cycle 3; next state FETCH.
- op 0000000 → illegal=1 in cycle 2, no reg_write or mem_write, FETCH in cycle 3.
- reset_n low during MEMADR → state FETCH immediately; write enables 0 while low; normal FETCH on release.
